// File: rtl/formant_envelope_gen_if.sv
// Stream bundle between a formant source and the envelope generator:
// formant frame strobe in, envelope bin stream out.
interface formant_envelope_gen_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5
) ();
    localparam int IW = $clog2(I);

    logic                                   formant_valid;
    logic [0:FORMANTS-1][BIT_WIDTH-1:0]     formant_freq;
    logic                                   env_valid;
    logic [BIT_WIDTH-1:0]                   env_data;
    logic [IW-1:0]                          env_index;
    logic                                   env_last;
    logic                                   busy;
    logic                                   dropped;

    modport master (
        output formant_valid, formant_freq,
        input  env_valid, env_data, env_index, env_last, busy, dropped
    );

    modport slave (
        input  formant_valid, formant_freq,
        output env_valid, env_data, env_index, env_last, busy, dropped
    );
endinterface

// File: rtl/formant_envelope_gen.sv
// Regenerates a piecewise-linear spectral envelope (I bins) from one frame of
// formant bin locations, through a 2-stage distance/falloff pipeline.
module formant_envelope_gen #(
    parameter int BIT_WIDTH   = 32,
    parameter int I           = 160,
    parameter int FORMANTS    = 5,
    parameter int PEAK        = 65536,
    parameter int SLOPE_SHIFT = 10,
    parameter int FLOOR       = 1
) (
    input logic                   clk_in,
    input logic                   rst_in,
    formant_envelope_gen_if.slave bus
);
    localparam int IW = $clog2(I);
    localparam int DW = IW + 1;
    localparam logic [BIT_WIDTH-1:0] I_W      = BIT_WIDTH'(I);
    localparam logic [IW-1:0]        LAST_BIN = IW'(I - 1);
    localparam logic [63:0]          PEAK_W   = 64'(PEAK);
    localparam logic [63:0]          FLOOR_W  = 64'(FLOOR);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;
    logic   busy_q, busy_next;
    logic   accept;
    logic   dropped_q;

    logic [IW-1:0]                      bin_cnt;
    logic [0:FORMANTS-1][BIT_WIDTH-1:0] freq_q;

    // stage 1
    logic                   v1, last1;
    logic [IW-1:0]          idx1;
    logic [FORMANTS-1:0]    present1, present_c;
    logic [DW-1:0]          dist1   [FORMANTS];
    logic [DW-1:0]          dist_c  [FORMANTS];

    // stage 2
    logic                   env_valid_q, env_last_q;
    logic [IW-1:0]          env_index_q;
    logic [BIT_WIDTH-1:0]   env_data_q;
    logic [63:0]            env_c;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.formant_valid && !busy_q) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN:     if (bin_cnt == LAST_BIN) state_next = DRAIN;
            // final bin is on the output this cycle, so the pipe is empty after the edge
            DRAIN:   if (env_valid_q && env_last_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            bin_cnt   <= '0;
            freq_q    <= '0;
        end else begin
            state     <= state_next;
            busy_q    <= busy_next;
            dropped_q <= bus.formant_valid && busy_q;
            if (accept) begin
                freq_q  <= bus.formant_freq;
                bin_cnt <= '0;
            end else if (state == RUN && bin_cnt != LAST_BIN) begin
                bin_cnt <= bin_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < FORMANTS; k++) begin
            logic [DW-1:0] b_ext, f_ext;
            b_ext        = {1'b0, bin_cnt};
            f_ext        = freq_q[k][DW-1:0];
            present_c[k] = (freq_q[k] < I_W);
            dist_c[k]    = (b_ext >= f_ext) ? (b_ext - f_ext) : (f_ext - b_ext);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1       <= 1'b0;
            last1    <= 1'b0;
            idx1     <= '0;
            present1 <= '0;
            for (int unsigned k = 0; k < FORMANTS; k++) dist1[k] <= '0;
        end else begin
            v1       <= (state == RUN);
            last1    <= (state == RUN) && (bin_cnt == LAST_BIN);
            idx1     <= bin_cnt;
            present1 <= present_c;
            for (int unsigned k = 0; k < FORMANTS; k++) dist1[k] <= dist_c[k];
        end
    end

    // falloff is evaluated wide so large distances saturate at 0 instead of wrapping
    always_comb begin
        env_c = '0;
        for (int unsigned k = 0; k < FORMANTS; k++) begin
            logic [63:0] shifted, contrib;
            shifted = 64'(dist1[k]) << SLOPE_SHIFT;
            contrib = (!present1[k] || shifted >= PEAK_W) ? 64'd0 : (PEAK_W - shifted);
            if (contrib > env_c) env_c = contrib;
        end
        if (env_c < FLOOR_W) env_c = FLOOR_W;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            env_valid_q <= 1'b0;
            env_last_q  <= 1'b0;
            env_index_q <= '0;
            env_data_q  <= '0;
        end else begin
            env_valid_q <= v1;
            env_last_q  <= last1;
            if (v1) begin
                env_index_q <= idx1;
                env_data_q  <= env_c[BIT_WIDTH-1:0];
            end
        end
    end

    assign bus.env_valid = env_valid_q;
    assign bus.env_data  = env_data_q;
    assign bus.env_index = env_index_q;
    assign bus.env_last  = env_last_q;
    assign bus.busy      = busy_q;
    assign bus.dropped   = dropped_q;
endmodule

// File: tb/tb_formant_envelope_gen.sv
// Directed bench for formant_envelope_gen: reset, single frame, absent/duplicate
// formants, busy collisions, back-to-back frames and mid-frame reset.
module tb_formant_envelope_gen;
    localparam int I     = 160;
    localparam int NH    = 2048;

    typedef int unsigned fset_t [5];

    logic clk_in = 1'b0;
    logic rst_in;
    int unsigned cyc = 0;

    formant_envelope_gen_if #(.BIT_WIDTH(32), .I(I), .FORMANTS(5)) bus ();

    formant_envelope_gen #(
        .BIT_WIDTH(32), .I(I), .FORMANTS(5),
        .PEAK(65536), .SLOPE_SHIFT(10), .FLOOR(1)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // per-cycle history of DUT outputs, sampled mid-cycle
    logic        v_h  [NH];
    logic [31:0] d_h  [NH];
    logic [7:0]  i_h  [NH];
    logic        l_h  [NH];
    logic        b_h  [NH];
    logic        dr_h [NH];
    logic        z_h  [NH];

    always @(negedge clk_in) begin
        if (cyc < NH) begin
            v_h[cyc]  = bus.env_valid;
            d_h[cyc]  = bus.env_data;
            i_h[cyc]  = bus.env_index;
            l_h[cyc]  = bus.env_last;
            b_h[cyc]  = bus.busy;
            dr_h[cyc] = bus.dropped;
            z_h[cyc]  = ({bus.env_valid, bus.env_last, bus.busy, bus.dropped,
                          bus.env_index, bus.env_data} == '0);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick();
    endtask

    // drives one strobe in the current cycle, then scrambles formant_freq
    task automatic strobe(input fset_t f);
        for (int k = 0; k < 5; k++) bus.formant_freq[k] = f[k];
        bus.formant_valid = 1'b1;
        tick();
        bus.formant_valid = 1'b0;
        for (int k = 0; k < 5; k++) bus.formant_freq[k] = 32'hDEAD_0000 + k;
    endtask

    function automatic int unsigned env_model(input fset_t f, input int b);
        int best = 0;
        for (int k = 0; k < 5; k++) begin
            if (f[k] < I) begin
                int d = (b > int'(f[k])) ? b - int'(f[k]) : int'(f[k]) - b;
                int c = 65536 - d * 1024;
                if (c > best) best = c;
            end
        end
        return (best < 1) ? 1 : best;
    endfunction

    task automatic check_stream(input string tag, input int unsigned start, input fset_t f);
        int errs = 0;
        if (v_h[start-1] !== 1'b0 || v_h[start+I] !== 1'b0) errs++;
        for (int n = 0; n < I; n++) begin
            int unsigned c = start + n;
            if (v_h[c] !== 1'b1 || i_h[c] !== 8'(n) || l_h[c] !== (n == I - 1) ||
                d_h[c] !== env_model(f, n))
                errs++;
        end
        check(tag, errs, 0);
    endtask

    fset_t f1   = '{10, 30, 60, 90, 120};
    fset_t f2   = '{200, 200, 5, 5, 159};
    fset_t fjnk = '{0, 0, 0, 0, 0};

    initial begin
        int unsigned r0, t1, t2, t3, t4, s1, s2;
        int cnt;

        rst_in = 1'b1;
        bus.formant_valid = 1'b0;
        bus.formant_freq  = '0;
        tick();
        tick();
        @(negedge clk_in);
        check("reset_outputs", {bus.env_valid, bus.env_last, bus.busy, bus.dropped,
                                bus.env_index, bus.env_data}, 64'd0);
        tick();
        rst_in = 1'b0;
        r0 = cyc;
        wait_until(r0 + 20);
        cnt = 0;
        for (int unsigned c = r0; c < r0 + 20; c++) cnt += int'(v_h[c]) + int'(b_h[c]);
        check("idle_quiet", cnt, 0);

        // frame 1, collision mid-frame, dropped strobe at t+162, accepted at t+163
        t1 = cyc;
        strobe(f1);
        wait_until(t1 + 50);
        strobe(fjnk);
        wait_until(t1 + 162);
        strobe(f2);
        t2 = cyc;
        strobe(f2);
        wait_until(t2 + 170);

        s1 = t1 + 3;
        check("busy_before", b_h[t1], 0);
        check("busy_rise", b_h[t1 + 1], 1);
        check("lat_t2_quiet", v_h[t1 + 2], 0);
        check("lat_t3_valid", v_h[t1 + 3], 1);
        check("f1_bin10", d_h[s1 + 10], 65536);
        check("f1_bin11", d_h[s1 + 11], 64512);
        check("f1_bin20", d_h[s1 + 20], 55296);
        check("f1_bin0", d_h[s1 + 0], 55296);
        check("f1_bin150", d_h[s1 + 150], 34816);
        check("f1_last_idx", i_h[t1 + 162], 159);
        check("f1_last_hi", l_h[t1 + 162], 1);
        check("f1_last_lo", l_h[t1 + 161], 0);
        check_stream("f1_stream", s1, f1);
        check("drop_quiet", dr_h[t1 + 50], 0);
        check("drop_pulse", dr_h[t1 + 51], 1);
        check("drop_1cyc", dr_h[t1 + 52], 0);
        check("busy_last_out", b_h[t1 + 162], 1);
        check("busy_fall", b_h[t1 + 163], 0);
        check("drop_at_fall", dr_h[t1 + 163], 1);
        check("accept_no_drop", dr_h[t1 + 164], 0);
        check("b2b_t2", t2, t1 + 163);

        s2 = t2 + 3;
        check("f2_start", v_h[s2] && !v_h[s2 - 1], 1);
        check("f2_bin5", d_h[s2 + 5], 65536);
        check("f2_bin159", d_h[s2 + 159], 65536);
        check("f2_bin82", d_h[s2 + 82], 1);
        check("f2_bin0", d_h[s2 + 0], 60416);
        check_stream("f2_stream", s2, f2);
        check("held_data", d_h[s2 + 162], 65536);
        check("held_index", i_h[s2 + 162], 159);

        // reset mid-frame with a coincident strobe
        wait_until(t2 + 180);
        t3 = cyc;
        strobe(f1);
        wait_until(t3 + 80);
        rst_in = 1'b1;
        bus.formant_valid = 1'b1;
        bus.formant_freq  = '0;
        tick();
        rst_in = 1'b0;
        bus.formant_valid = 1'b0;
        wait_until(t3 + 110);
        check("rst_mid_prev_valid", v_h[t3 + 80], 1);
        check("rst_mid_zero", z_h[t3 + 81], 1);
        cnt = 0;
        for (int unsigned c = t3 + 81; c < t3 + 110; c++) cnt += int'(v_h[c]) + int'(b_h[c]);
        check("rst_mid_quiet", cnt, 0);

        t4 = cyc;
        strobe(f1);
        wait_until(t4 + 170);
        check_stream("post_rst_stream", t4 + 3, f1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
